// File: rtl/freq_div_prog.sv
// freq_div_prog: runtime-programmable clock divider / clock-enable generator.
//
// Divides i_clk by a loadable divisor N. A new divisor is held as pending
// and only applied at a period boundary (wrap or sync clear), so the output
// never shows a runt or stretched period.
//
// Ports
//   i_clk          system clock, all state updates on the rising edge
//   i_reset        synchronous active-low reset
//   i_en           count enable; low freezes counter and outputs
//   i_div_in       new divisor value (values below 2 are stored as 2)
//   i_div_load     one-cycle strobe capturing i_div_in
//   i_sync_clr     phase restart: counter to 0, pending/new divisor applied
//   i_mode         0 = square wave on o_clk_out, 1 = pulse train
//   o_clk_out      divided output
//   o_tick         one-cycle pulse in the last cycle of each period
//   o_div_active   divisor currently in effect
//   o_div_pending  a loaded divisor is waiting for a boundary
module freq_div_prog #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_div_in,
  input  logic             i_div_load,
  input  logic             i_sync_clr,
  input  logic             i_mode,
  output logic             o_clk_out,
  output logic             o_tick,
  output logic [WIDTH-1:0] o_div_active,
  output logic             o_div_pending
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_div_active;
  logic [WIDTH-1:0] r_pend_val;
  logic             r_pend_vld;

  logic [WIDTH-1:0] w_last;
  logic [WIDTH-1:0] w_half;
  logic [WIDTH-1:0] w_div_clamped;
  logic             w_at_last;
  logic             w_wrap;

  // N >= 2 always holds, so N-1 never underflows.
  assign w_last        = r_div_active - WIDTH'(1);
  assign w_at_last     = (r_cnt == w_last);
  assign w_wrap        = i_en && w_at_last;
  // ceil(N/2); fits in WIDTH bits even for N = 2^WIDTH-1.
  assign w_half        = (r_div_active >> 1) + {{(WIDTH-1){1'b0}}, r_div_active[0]};
  assign w_div_clamped = (i_div_in < WIDTH'(2)) ? WIDTH'(2) : i_div_in;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cnt        <= '0;
      r_div_active <= WIDTH'(DEFAULT_DIV);
      r_pend_val   <= '0;
      r_pend_vld   <= 1'b0;
    end else if (i_sync_clr) begin
      // Clear acts regardless of i_en and is itself a period boundary.
      r_cnt      <= '0;
      r_pend_vld <= 1'b0;
      if (i_div_load) begin
        r_div_active <= w_div_clamped;
      end else if (r_pend_vld) begin
        r_div_active <= r_pend_val;
      end
    end else begin
      if (i_en) begin
        r_cnt <= w_at_last ? '0 : r_cnt + WIDTH'(1);
      end
      if (w_wrap) begin
        // A load coinciding with the wrap bypasses the pending stage.
        r_pend_vld <= 1'b0;
        if (i_div_load) begin
          r_div_active <= w_div_clamped;
        end else if (r_pend_vld) begin
          r_div_active <= r_pend_val;
        end
      end else if (i_div_load) begin
        // Loads are captured even while i_en is low; last one wins.
        r_pend_val <= w_div_clamped;
        r_pend_vld <= 1'b1;
      end
    end
  end

  assign o_tick        = w_at_last;
  assign o_clk_out     = i_mode ? w_at_last : (r_cnt >= w_half);
  assign o_div_active  = r_div_active;
  assign o_div_pending = r_pend_vld;

endmodule

// File: tb/tb_freq_div_prog.sv
module tb_freq_div_prog;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [W-1:0] div_in;
  logic         div_load;
  logic         sync_clr;
  logic         mode;
  logic         clk_out;
  logic         tick;
  logic [W-1:0] div_active;
  logic         div_pending;

  int n_pass  = 0;
  int n_total = 0;
  bit done    = 1'b0;

  typedef struct {
    logic         c;
    logic         t;
    logic [W-1:0] a;
    logic         p;
    string        nm;
  } exp_t;

  exp_t sb_q[$];

  freq_div_prog #(.WIDTH(W), .DEFAULT_DIV(4)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_en         (en),
    .i_div_in     (div_in),
    .i_div_load   (div_load),
    .i_sync_clr   (sync_clr),
    .i_mode       (mode),
    .o_clk_out    (clk_out),
    .o_tick       (tick),
    .o_div_active (div_active),
    .o_div_pending(div_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, req);
  endtask

  // Monitor: outputs are presented every cycle; compare 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({e.nm, ".clk_out"},     W'(clk_out),     W'(e.c));
        chk({e.nm, ".tick"},        W'(tick),        W'(e.t));
        chk({e.nm, ".div_active"},  div_active,      e.a);
        chk({e.nm, ".div_pending"}, W'(div_pending), W'(e.p));
      end
    end
  end

  // Drive inputs for the next edge and push the state expected after it.
  task automatic step(input logic rst_n, input logic e_n, input logic ld,
                      input logic [W-1:0] din, input logic clr, input logic md,
                      input logic ec, input logic et, input logic [W-1:0] ea,
                      input logic ep, input string nm);
    exp_t x;
    @(negedge clk);
    reset    = rst_n;
    en       = e_n;
    div_load = ld;
    div_in   = din;
    sync_clr = clr;
    mode     = md;
    x.c = ec; x.t = et; x.a = ea; x.p = ep; x.nm = nm;
    sb_q.push_back(x);
  endtask

  // Plain counting step with en=1 and no strobes.
  task automatic run(input logic md, input logic ec, input logic et,
                     input logic [W-1:0] ea, input logic ep, input string nm);
    step(1, 1, 0, 0, 0, md, ec, et, ea, ep, nm);
  endtask

  initial begin
    reset = 0; en = 0; div_in = 0; div_load = 0; sync_clr = 0; mode = 0;

    // 1: reset, then default N=4 square wave 0,0,1,1
    step(0, 0, 0, 0, 0, 0, 0, 0, 4, 0, "rst0");
    step(0, 1, 1, 9, 1, 0, 0, 0, 4, 0, "rst1");
    run(0, 0, 0, 4, 0, "n4_c1");
    run(0, 1, 0, 4, 0, "n4_c2");
    run(0, 1, 1, 4, 0, "n4_c3");
    run(0, 0, 0, 4, 0, "n4_c0");
    run(0, 0, 0, 4, 0, "n4b_c1");
    run(0, 1, 0, 4, 0, "n4b_c2");
    run(0, 1, 1, 4, 0, "n4b_c3");
    run(0, 0, 0, 4, 0, "n4b_c0");

    // 2: load 5 at cnt=1; period finishes at N=4, then N=5
    run(0, 0, 0, 4, 0, "pre_c1");
    step(1, 1, 1, 5, 0, 0, 1, 0, 4, 1, "ld5_c2");
    run(0, 1, 1, 4, 1, "ld5_c3");
    run(0, 0, 0, 5, 0, "n5_c0");
    run(0, 0, 0, 5, 0, "n5_c1");
    run(0, 0, 0, 5, 0, "n5_c2");
    run(0, 1, 0, 5, 0, "n5_c3");
    run(0, 1, 1, 5, 0, "n5_c4");
    run(0, 0, 0, 5, 0, "n5_c0b");

    // 3: load 7 exactly on wrap (bypass), then clamp 0 and 1 to N=2
    run(0, 0, 0, 5, 0, "n5w_c1");
    run(0, 0, 0, 5, 0, "n5w_c2");
    run(0, 1, 0, 5, 0, "n5w_c3");
    run(0, 1, 1, 5, 0, "n5w_c4");
    step(1, 1, 1, 7, 0, 0, 0, 0, 7, 0, "byp7_c0");
    run(0, 0, 0, 7, 0, "n7_c1");
    run(0, 0, 0, 7, 0, "n7_c2");
    run(0, 0, 0, 7, 0, "n7_c3");
    run(0, 1, 0, 7, 0, "n7_c4");
    run(0, 1, 0, 7, 0, "n7_c5");
    run(0, 1, 1, 7, 0, "n7_c6");
    run(0, 0, 0, 7, 0, "n7_c0");
    step(1, 1, 1, 0, 0, 0, 0, 0, 7, 1, "ld0_c1");
    run(0, 0, 0, 7, 1, "p2_c2");
    run(0, 0, 0, 7, 1, "p2_c3");
    run(0, 1, 0, 7, 1, "p2_c4");
    run(0, 1, 0, 7, 1, "p2_c5");
    run(0, 1, 1, 7, 1, "p2_c6");
    run(0, 0, 0, 2, 0, "n2_c0");
    run(0, 1, 1, 2, 0, "n2_c1");
    run(0, 0, 0, 2, 0, "n2_c0b");
    run(0, 1, 1, 2, 0, "n2_c1b");
    step(1, 1, 1, 1, 0, 0, 0, 0, 2, 0, "byp1_c0");
    run(0, 1, 1, 2, 0, "n2_c1c");
    step(1, 1, 1, 6, 0, 0, 0, 0, 6, 0, "byp6_c0");

    // 4: pulse mode N=6, en dropped for 3 cycles at cnt=2
    run(1, 0, 0, 6, 0, "p6_c1");
    run(1, 0, 0, 6, 0, "p6_c2");
    run(1, 0, 0, 6, 0, "p6_c3");
    run(1, 0, 0, 6, 0, "p6_c4");
    run(1, 1, 1, 6, 0, "p6_c5");
    run(1, 0, 0, 6, 0, "p6_c0");
    run(1, 0, 0, 6, 0, "p6b_c1");
    run(1, 0, 0, 6, 0, "p6b_c2");
    step(1, 0, 0, 0, 0, 1, 0, 0, 6, 0, "hold1");
    step(1, 0, 0, 0, 0, 1, 0, 0, 6, 0, "hold2");
    step(1, 0, 0, 0, 0, 1, 0, 0, 6, 0, "hold3");
    run(1, 0, 0, 6, 0, "p6b_c3");
    run(1, 0, 0, 6, 0, "p6b_c4");
    run(1, 1, 1, 6, 0, "p6b_c5");
    run(1, 0, 0, 6, 0, "p6b_c0");

    // 5: pending 3, sync_clr at cnt=2 -> cnt=0, N=3, no tick
    step(1, 1, 1, 3, 0, 1, 0, 0, 6, 1, "ld3_c1");
    run(1, 0, 0, 6, 1, "ld3_c2");
    step(1, 1, 0, 0, 1, 1, 0, 0, 3, 0, "clr_c0");
    run(1, 0, 0, 3, 0, "n3p_c1");
    run(1, 1, 1, 3, 0, "n3p_c2");
    run(1, 0, 0, 3, 0, "n3p_c0");
    run(0, 0, 0, 3, 0, "n3s_c1");
    run(0, 1, 1, 3, 0, "n3s_c2");
    run(0, 0, 0, 3, 0, "n3s_c0");

    // 6: load while en=0 sets pending; reset mid-period overrides everything
    run(0, 0, 0, 3, 0, "n3s_c1b");
    step(1, 0, 1, 9, 0, 0, 0, 0, 3, 1, "ld9_hold");
    step(0, 1, 1, 10, 1, 0, 0, 0, 4, 0, "rst_mid");
    run(0, 0, 0, 4, 0, "post_c1");
    run(0, 1, 0, 4, 0, "post_c2");
    run(0, 1, 1, 4, 0, "post_c3");

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    if (sb_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
